ro_slot_sched: RTL and testbench

//  Readout slot scheduler for the pol/pol_eve comparator array. Snapshots all channels
//  at frame start and walks them one slot per clk. Drives one-hot tri-state enables and
//  the serialised pol/pol_eve bits onto the shared readout lines.

---
 rtl/ro_slot_sched_if.sv | 33 +++
 rtl/ro_slot_sched.sv | 139 +++++++++++++
 tb/tb_ro_slot_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ro_slot_sched_if.sv
// Readout-slot bus between the scheduler and its environment:
// channel inputs in, framed one-hot select and serial pol/pol_eve out.
interface ro_slot_sched_if #(
  parameter int N_CH   = 16,
  parameter int SLOT_W = 4,
  parameter int FCNT_W = 8
);
  logic              en;
  logic [N_CH-1:0]   ch_mask;
  logic [N_CH-1:0]   in_pol;
  logic [N_CH-1:0]   in_pol_eve;
  logic              frame_start;
  logic              busy;
  logic [SLOT_W-1:0] slot_idx;
  logic [SLOT_W-1:0] gray_slot;
  logic [N_CH-1:0]   sel_onehot;
  logic              out_pol;
  logic              out_pol_eve;
  logic              out_valid;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output en, ch_mask, in_pol, in_pol_eve,
    input  frame_start, busy, slot_idx, gray_slot, sel_onehot,
           out_pol, out_pol_eve, out_valid, frame_cnt
  );

  modport slave (
    input  en, ch_mask, in_pol, in_pol_eve,
    output frame_start, busy, slot_idx, gray_slot, sel_onehot,
           out_pol, out_pol_eve, out_valid, frame_cnt
  );
endinterface

// File: rtl/ro_slot_sched.sv
// Readout slot scheduler: snapshots all channels in SYNC, then walks one slot per clk,
// driving a one-hot tri-state enable and the masked pol/pol_eve bits; GAP separates frames.
module ro_slot_sched #(
  parameter int N_CH      = 16,
  parameter int SLOT_W    = 4,
  parameter int FRAME_GAP = 2,
  parameter int FCNT_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  ro_slot_sched_if.slave  bus
);
  localparam int GAP_W = $clog2(FRAME_GAP + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    SCAN = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [N_CH-1:0]   snap_pol_q, snap_pol_d;
  logic [N_CH-1:0]   snap_eve_q, snap_eve_d;
  logic              frame_start_q, frame_start_d;
  logic              busy_q, busy_d;
  logic [SLOT_W-1:0] gray_q, gray_d;
  logic [N_CH-1:0]   sel_q, sel_d;
  logic              out_pol_q, out_pol_d;
  logic              out_eve_q, out_eve_d;
  logic              valid_q, valid_d;

  // State, counters, snapshots and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      gap_q         <= '0;
      fcnt_q        <= '0;
      mask_q        <= '0;
      snap_pol_q    <= '0;
      snap_eve_q    <= '0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      gray_q        <= '0;
      sel_q         <= '0;
      out_pol_q     <= 1'b0;
      out_eve_q     <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      gap_q         <= gap_d;
      fcnt_q        <= fcnt_d;
      mask_q        <= mask_d;
      snap_pol_q    <= snap_pol_d;
      snap_eve_q    <= snap_eve_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      gray_q        <= gray_d;
      sel_q         <= sel_d;
      out_pol_q     <= out_pol_d;
      out_eve_q     <= out_eve_d;
      valid_q       <= valid_d;
    end
  end

  // Next-state, slot/gap counters and completed-frame counter.
  always_comb begin
    state_d = state_q;
    slot_d  = '0;
    gap_d   = '0;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.en) state_d = SYNC;
        else        state_d = IDLE;
      end
      SYNC: state_d = SCAN;
      SCAN: begin
        if (slot_q == SLOT_W'(N_CH - 1)) begin
          fcnt_d = fcnt_q + FCNT_W'(1);
          if (FRAME_GAP > 0) state_d = GAP;
          else if (bus.en)   state_d = SYNC;
          else               state_d = IDLE;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(FRAME_GAP - 1)) begin
          if (bus.en) state_d = SYNC;
          else        state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from next-state values so the registered copies line up with state_q;
  // the snapshot feeds slot 0 on the same edge it is captured.
  always_comb begin
    if (state_q == SYNC) begin
      mask_d     = bus.ch_mask;
      snap_pol_d = bus.in_pol;
      snap_eve_d = bus.in_pol_eve;
    end else begin
      mask_d     = mask_q;
      snap_pol_d = snap_pol_q;
      snap_eve_d = snap_eve_q;
    end
    sel_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      sel_d[k] = (state_d == SCAN) && (slot_d == SLOT_W'(k)) && mask_d[k];
    end
    frame_start_d = (state_d == SYNC);
    busy_d        = (state_d != IDLE);
    gray_d        = slot_d ^ (slot_d >> 1);
    out_pol_d     = |(sel_d & snap_pol_d);
    out_eve_d     = |(sel_d & snap_eve_d);
    valid_d       = |sel_d;
  end

  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
  assign bus.slot_idx    = slot_q;
  assign bus.gray_slot   = gray_q;
  assign bus.sel_onehot  = sel_q;
  assign bus.out_pol     = out_pol_q;
  assign bus.out_pol_eve = out_eve_q;
  assign bus.out_valid   = valid_q;
  assign bus.frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_ro_slot_sched.sv
// Directed bench for ro_slot_sched: per-frame expectations queued at SYNC, popped per slot.
module tb_ro_slot_sched;
  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   last_fs = 0;
  logic [7:0] fcnt_exp = 8'd0;

  typedef struct packed {
    logic [3:0]  slot;
    logic [15:0] sel;
    logic        pol;
    logic        eve;
    logic        valid;
  } exp_t;
  exp_t sb[$];

  ro_slot_sched_if #(.N_CH(16), .SLOT_W(4), .FCNT_W(8)) bus ();

  ro_slot_sched #(.N_CH(16), .SLOT_W(4), .FRAME_GAP(2), .FCNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("gray", {28'd0, bus.gray_slot}, {28'd0, bus.slot_idx ^ (bus.slot_idx >> 1)});
    chk("onehot0", {31'd0, $onehot0(bus.sel_onehot)}, 32'd1);
    chk("valid_or", {31'd0, bus.out_valid}, {31'd0, |bus.sel_onehot});
  endtask

  task automatic chk_idle_outs(input string tag);
    chk(tag, {4'd0, bus.frame_start, bus.busy, bus.slot_idx, bus.gray_slot, bus.sel_onehot,
              bus.out_pol, bus.out_pol_eve, bus.out_valid}, 32'd0);
  endtask

  task automatic do_frame(input logic [15:0] m, input logic [15:0] p, input logic [15:0] e,
                          input bit toggle, input int drop_slot, input int reset_slot,
                          input bit b2b);
    bit   found = 1'b0;
    exp_t x;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (bus.frame_start === 1'b1) found = 1'b1;
    end
    chk("fs_found", {31'd0, found}, 32'd1);
    if (b2b) chk("fs_spacing", cyc - last_fs, 32'd19);
    last_fs = cyc;
    chk("sync_busy", {31'd0, bus.busy}, 32'd1);
    chk("sync_outs", {bus.slot_idx, bus.sel_onehot, bus.out_valid}, 32'd0);
    bus.ch_mask    = m;
    bus.in_pol     = p;
    bus.in_pol_eve = e;
    for (int k = 0; k < 16; k++) begin
      x.slot  = 4'(k);
      x.sel   = m[k] ? (16'd1 << k) : 16'd0;
      x.pol   = p[k] & m[k];
      x.eve   = e[k] & m[k];
      x.valid = m[k];
      sb.push_back(x);
    end
    for (int k = 0; k < 16; k++) begin
      step();
      x = sb.pop_front();
      chk("slot_idx", {28'd0, bus.slot_idx}, {28'd0, x.slot});
      chk("sel", {16'd0, bus.sel_onehot}, {16'd0, x.sel});
      chk("out_pol", {31'd0, bus.out_pol}, {31'd0, x.pol});
      chk("out_pol_eve", {31'd0, bus.out_pol_eve}, {31'd0, x.eve});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, x.valid});
      chk("scan_busy", {30'd0, bus.busy, bus.frame_start}, 32'd2);
      if (toggle) begin
        bus.in_pol     = 16'($urandom);
        bus.in_pol_eve = 16'($urandom);
        bus.ch_mask    = 16'($urandom);
      end
      if (k == drop_slot) bus.en = 1'b0;
      if (k == reset_slot) begin
        reset = 1'b1;
        step();
        chk_idle_outs("rst_mid_outs");
        chk("rst_mid_fcnt", {24'd0, bus.frame_cnt}, {24'd0, fcnt_exp});
        reset   = 1'b0;
        bus.en  = 1'b0;
        sb.delete();
        step();
        chk("rst_mid_idle", {31'd0, bus.busy}, 32'd0);
        return;
      end
    end
    fcnt_exp = fcnt_exp + 8'd1;
    for (int g = 0; g < 2; g++) begin
      step();
      chk("gap_busy", {31'd0, bus.busy}, 32'd1);
      chk("gap_outs", {bus.frame_start, bus.slot_idx, bus.sel_onehot, bus.out_pol,
                       bus.out_pol_eve, bus.out_valid}, 32'd0);
      chk("frame_cnt", {24'd0, bus.frame_cnt}, {24'd0, fcnt_exp});
    end
    if (!bus.en) begin
      step();
      chk("end_idle", {30'd0, bus.busy, bus.frame_start}, 32'd0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.en         = 1'b0;
    bus.ch_mask    = 16'h0000;
    bus.in_pol     = 16'h0000;
    bus.in_pol_eve = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle_outs("reset_outs");
      chk("reset_fcnt", {24'd0, bus.frame_cnt}, 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_idle_outs("idle_outs");
    end

    bus.en = 1'b1;
    do_frame(16'hFFFF, 16'hA5C3, 16'h5A3C, 1'b0, -1, -1, 1'b0);
    do_frame(16'h00F0, 16'hFFFF, 16'h0F0F, 1'b0, -1, -1, 1'b1);
    do_frame(16'hFFFF, 16'h1234, 16'h8001, 1'b1, -1, -1, 1'b1);
    do_frame(16'hBEEF, 16'hC0DE, 16'h7A55, 1'b1, 5, -1, 1'b1);

    bus.en = 1'b1;
    for (int i = 0; i < 252; i++) begin
      do_frame(16'($urandom), 16'($urandom), 16'($urandom), 1'b1,
               (i == 251) ? 3 : -1, -1, (i != 0));
    end
    chk("fcnt_wrap", {24'd0, bus.frame_cnt}, 32'd0);

    bus.en = 1'b1;
    do_frame(16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0, -1, 9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
